// File: rtl/mont_pkg.sv
// mont_pkg: shared definitions for the Montgomery constant generator.
//   - FSM state encodings for the IDLE -> RUN -> DONE sequence
//   - helper functions deriving the iteration counter width and the
//     LEN+1 working width used by the R^2 reduction track
package mont_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_LEN = 2048;

  // Counter must reach 2*LEN-1; sized so 2*LEN itself is representable.
  function automatic int cnt_width(input int len);
    return $clog2(2 * len + 1);
  endfunction

  // The doubling step briefly holds 2r, which needs one bit above LEN.
  function automatic int work_width(input int len);
    return len + 1;
  endfunction

endpackage

// File: rtl/mod_double_step.sv
// mod_double_step: one combinational modular-doubling step.
//   r_next = (2r >= n) ? 2r - n : 2r
// Ports:
//   r      in   W  current residue, assumed < n
//   n      in   W  modulus (zero-extended by the caller)
//   r_next out  W  2r reduced once modulo n
module mod_double_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] n,
  output logic [W-1:0] r_next
);

  logic [W:0] t;
  logic [W:0] n_ext;

  // Doubling is done one bit wider so the compare never sees a wrapped value.
  assign t      = {r, 1'b0};
  assign n_ext  = {1'b0, n};
  assign r_next = (t >= n_ext) ? W'(t - n_ext) : t[W-1:0];

endmodule

// File: rtl/mont_param_gen.sv
// mont_param_gen: bit-serial generator of the two Montgomery constants
//   n_prime  = -n^-1 mod 2^LEN
//   r2_mod_n = 2^(2*LEN) mod n
// One iteration per clock, 2*LEN iterations per run, start/done handshake.
//
// Optional feature macro: MONT_PARAM_CHECK_EN
//   defined   - an even (or zero) modulus is rejected at start: err=1 and
//               both results 0, reported without running the iterations.
//   undefined - no check, err is tied low; the caller guarantees odd n.
//
// Ports:
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous active-high reset
//   start     in   1    run request, only looked at while idle
//   n         in   LEN  modulus, captured when start is accepted
//   busy      out  1    iterations in progress
//   done      out  1    one-cycle pulse, results valid
//   err       out  1    modulus rejected (only with MONT_PARAM_CHECK_EN)
//   n_prime   out  LEN  -n^-1 mod 2^LEN
//   r2_mod_n  out  LEN  2^(2*LEN) mod n
module mont_param_gen
  import mont_pkg::*;
#(
  parameter int LEN = DEFAULT_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [LEN-1:0] n_prime,
  output logic [LEN-1:0] r2_mod_n
);

  localparam int CNT_W = cnt_width(LEN);
  localparam int WW    = work_width(LEN);
  localparam int IDX_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * LEN - 1);
  localparam logic [CNT_W-1:0] CNT_INV  = CNT_W'(LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [LEN-1:0]   n_q;
  logic [LEN-1:0]   np;
  logic [LEN-1:0]   s;
  logic [WW-1:0]    r;
  logic [WW-1:0]    r_next;
  logic [IDX_W-1:0] idx;
  logic             inv_active;

  // While cnt < LEN it fits in IDX_W bits, so the low slice is a safe bit index.
  assign idx        = cnt[IDX_W-1:0];
  assign inv_active = (cnt < CNT_INV);
  assign busy       = (state == ST_RUN);

  mod_double_step #(
    .W(WW)
  ) u_double (
    .r      (r),
    .n      ({1'b0, n_q}),
    .r_next (r_next)
  );

`ifdef MONT_PARAM_CHECK_EN
  logic bad_q;
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Main sequencer. The inverse track builds np one bit per step by keeping
  // s = n*np + 1 mod 2^LEN and clearing its lowest set bit; the R^2 track
  // doubles r modulo n 2*LEN times starting from 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      n_q      <= '0;
      np       <= '0;
      s        <= '0;
      r        <= '0;
      done     <= 1'b0;
      n_prime  <= '0;
      r2_mod_n <= '0;
`ifdef MONT_PARAM_CHECK_EN
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q <= n;
            np  <= '0;
            s   <= LEN'(1);
            // For n == 1 every residue is 0, so start the R^2 track there.
            r   <= (n == LEN'(1)) ? '0 : WW'(1);
            cnt <= '0;
`ifdef MONT_PARAM_CHECK_EN
            err_q <= 1'b0;
            if (!n[0]) begin
              bad_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              bad_q <= 1'b0;
              state <= ST_RUN;
            end
`else
            state <= ST_RUN;
`endif
          end
        end

        ST_RUN: begin
          if (inv_active && s[idx]) begin
            np[idx] <= 1'b1;
            s       <= s + (n_q << idx);
          end
          r   <= r_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
`ifdef MONT_PARAM_CHECK_EN
          if (bad_q) begin
            err_q    <= 1'b1;
            n_prime  <= '0;
            r2_mod_n <= '0;
          end else begin
            n_prime  <= np;
            r2_mod_n <= r[LEN-1:0];
          end
`else
          n_prime  <= np;
          r2_mod_n <= r[LEN-1:0];
`endif
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_param_gen.sv
// tb_mont_param_gen: directed-vector bench for mont_param_gen at LEN=8.
// Stimulus pushes the hand-computed result, the cycle on which done must be
// seen and the expected busy length into a queue; an independent monitor
// pops and compares whenever done is observed.
module tb_mont_param_gen;

  localparam int LEN  = 8;
  localparam int LAT  = 2 * LEN + 1;
  localparam int BUSY = 2 * LEN;

  typedef struct {
    logic [7:0] nv;
    logic [7:0] np;
    logic [7:0] r2;
    logic       e;
    int         cyc;
    int         busy_n;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] n;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] n_prime;
  logic [7:0] r2_mod_n;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   busy_cnt;
  int   done_total;

  mont_param_gen #(
    .LEN(LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .n_prime  (n_prime),
    .r2_mod_n (r2_mod_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to time-stamp expected done pulses.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: count busy cycles and score each done pulse against the queue.
  initial begin
    busy_cnt   = 0;
    done_total = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
          exp_t e;
          done_total++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done got done=1 want no done at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            $display("[TB] done for n=%02h at cycle %0d", e.nv, cyc);
            compare_val("n_prime", 32'(n_prime), 32'(e.np));
            compare_val("r2_mod_n", 32'(r2_mod_n), 32'(e.r2));
            compare_val("err", 32'(err), 32'(e.e));
            compare_val("done_cycle", 32'(cyc), 32'(e.cyc));
            compare_val("busy_len", 32'(busy_cnt), 32'(e.busy_n));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] nv, input logic [7:0] np, input logic [7:0] r2,
                                input logic e, input int lat, input int bz);
    exp_t x;
    @(negedge clk);
    n     = nv;
    start = 1'b1;
    x.nv = nv; x.np = np; x.r2 = r2; x.e = e; x.cyc = cyc + 1 + lat; x.busy_n = bz;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    n     = 8'hA6;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_output(input string tag);
    compare_val({tag, "_n_prime"}, 32'(n_prime), 32'h0);
    compare_val({tag, "_r2_mod_n"}, 32'(r2_mod_n), 32'h0);
    compare_val({tag, "_done"}, 32'(done), 32'h0);
    compare_val({tag, "_busy"}, 32'(busy), 32'h0);
    compare_val({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int dt;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    n      = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset");
    rst = 1'b0;

    // Basic vectors: results, latency and busy length.
    apply_stimulus(8'hF1, 8'hEF, 8'hE1, 1'b0, LAT, BUSY); wait_drain();
    apply_stimulus(8'h03, 8'h55, 8'h01, 1'b0, LAT, BUSY); wait_drain();
    apply_stimulus(8'h01, 8'hFF, 8'h00, 1'b0, LAT, BUSY); wait_drain();
`ifdef MONT_PARAM_CHECK_EN
    apply_stimulus(8'h10, 8'h00, 8'h00, 1'b1, 1, 0); wait_drain();
`else
    apply_stimulus(8'h10, 8'h11, 8'h00, 1'b0, LAT, BUSY); wait_drain();
`endif
    apply_stimulus(8'hFF, 8'h01, 8'h01, 1'b0, LAT, BUSY); wait_drain();
    apply_stimulus(8'h05, 8'h33, 8'h01, 1'b0, LAT, BUSY); wait_drain();
    apply_stimulus(8'h07, 8'h49, 8'h02, 1'b0, LAT, BUSY); wait_drain();

    // A start while busy must be ignored: exactly one done.
    dt = done_total;
    apply_stimulus(8'hF1, 8'hEF, 8'hE1, 1'b0, LAT, BUSY);
    @(negedge clk);
    start = 1'b1;
    n     = 8'h03;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);
    compare_val("ignored_start_done_count", 32'(done_total - dt), 32'd1);

    // Reset mid-run aborts without a done and clears the outputs.
    dt = done_total;
    apply_stimulus(8'hF1, 8'hEF, 8'hE1, 1'b0, LAT, BUSY);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_output("abort");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    compare_val("abort_no_done", 32'(done_total - dt), 32'd0);
    apply_stimulus(8'h03, 8'h55, 8'h01, 1'b0, LAT, BUSY); wait_drain();

    // Start held high: second run begins on the idle cycle after done.
    begin
      exp_t x;
      @(negedge clk);
      base  = cyc;
      n     = 8'hF1;
      start = 1'b1;
      x.nv = 8'hF1; x.np = 8'hEF; x.r2 = 8'hE1; x.e = 1'b0; x.cyc = base + 1 + LAT; x.busy_n = BUSY;
      sb.push_back(x);
      x.nv = 8'h03; x.np = 8'h55; x.r2 = 8'h01; x.e = 1'b0; x.cyc = base + 1 + LAT + 1 + LAT; x.busy_n = BUSY;
      sb.push_back(x);
      @(negedge clk);
      n = 8'h03;
      while (cyc < base + LAT + 2) @(negedge clk);
      start = 1'b0;
      n     = 8'h5A;
    end
    wait_drain();
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
